// File: rtl/store_trace_fifo.sv
// Circular trace FIFO of committed data-memory stores (PC, address, data, byte mask), popped by VIO.
// Optional macro STORE_TRACE_TIMESTAMP_EN adds a 16-bit cycle timestamp per entry (head_ts).
module store_trace_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        we,
    input  logic [31:0]       PC,
    input  logic [31:0]       daddr,
    input  logic [31:0]       dwdata,
    input  logic              pop_req,
    input  logic              clear,
    output logic [31:0]       head_pc,
    output logic [31:0]       head_addr,
    output logic [31:0]       head_data,
    output logic [3:0]        head_we,
`ifdef STORE_TRACE_TIMESTAMP_EN
    output logic [15:0]       head_ts,
`endif
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

`ifdef STORE_TRACE_TIMESTAMP_EN
    localparam int unsigned EntryW = 116;
`else
    localparam int unsigned EntryW = 100;
`endif
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

    logic [EntryW-1:0] mem_q [DEPTH];
    logic [EntryW-1:0] entry_in;
    logic [EntryW-1:0] rd_entry;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              s1_q, s2_q, s3_q;
    logic              pop_pulse, pop_ok, push, push_ok, mem_we;

`ifdef STORE_TRACE_TIMESTAMP_EN
    logic [15:0] ts_cnt_q, ts_cnt_d;

    assign ts_cnt_d = ts_cnt_q + 16'd1;
    assign entry_in = {ts_cnt_q, PC, daddr, dwdata, we};

    // Free-running; deliberately untouched by clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_cnt_q <= '0;
        else       ts_cnt_q <= ts_cnt_d;
    end
`else
    assign entry_in = {PC, daddr, dwdata, we};
`endif

    assign empty     = (count_q == '0);
    assign full      = (count_q == DepthCnt);
    assign pop_pulse = s2_q & ~s3_q;
    assign pop_ok    = pop_pulse && !empty;
    assign push      = (we != 4'b0);
    // A pop on the same edge frees the slot being written when full.
    assign push_ok   = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            mem_we = push_ok;
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
            else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
            if (push && !push_ok) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            s1_q       <= pop_req;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= entry_in;
    end

    assign rd_entry  = mem_q[rd_ptr_q];
    assign head_we   = empty ? 4'b0  : rd_entry[3:0];
    assign head_data = empty ? 32'b0 : rd_entry[35:4];
    assign head_addr = empty ? 32'b0 : rd_entry[67:36];
    assign head_pc   = empty ? 32'b0 : rd_entry[99:68];
`ifdef STORE_TRACE_TIMESTAMP_EN
    assign head_ts   = empty ? 16'b0 : rd_entry[115:100];
`endif

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_store_trace_fifo.sv
// Scoreboard bench for store_trace_fifo: expected entries queued at store time, checked at pop.
module tb_store_trace_fifo;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  we;
    logic [31:0] pc, daddr, dwdata;
    logic        pop_req, clear;
    logic [31:0] head_pc, head_addr, head_data;
    logic [3:0]  head_we;
    logic [4:0]  count;
    logic        empty, full, overflow;
`ifdef STORE_TRACE_TIMESTAMP_EN
    logic [15:0] head_ts;
`endif

    logic [99:0] exp_q [$];
    logic        exp_ovf;
    int          n_checks = 0;
    int          n_fail = 0;

    store_trace_fifo #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .we(we), .PC(pc), .daddr(daddr), .dwdata(dwdata),
        .pop_req(pop_req), .clear(clear), .head_pc(head_pc), .head_addr(head_addr),
        .head_data(head_data), .head_we(head_we),
`ifdef STORE_TRACE_TIMESTAMP_EN
        .head_ts(head_ts),
`endif
        .count(count), .empty(empty), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [99:0] mk(input int i);
        return {32'(i * 4), 32'h1000 + 32'(i * 4), 32'(i), 4'((i % 15) + 1)};
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_store(input logic [99:0] e);
        {pc, daddr, dwdata, we} = e;
        @(posedge clk); #1;
        we = 4'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else exp_ovf = 1'b1;
    endtask

    task automatic do_pop(input int hold, input bit with_store, input logic [99:0] st);
        logic [99:0] exp_head;
        logic [4:0]  cnt_before;
        exp_head = (exp_q.size() > 0) ? exp_q[0] : 100'b0;
        cnt_before = 5'(exp_q.size());
        n_checks++;
        if ({head_pc, head_addr, head_data, head_we} !== exp_head) begin
            n_fail++;
            $display("FAIL pop_head: got %h expected %h", {head_pc, head_addr, head_data, head_we},
                     exp_head);
        end
        pop_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (count !== cnt_before) begin
            n_fail++;
            $display("FAIL pop_latency_early: count %0d expected %0d", count, cnt_before);
        end
        if (with_store) {pc, daddr, dwdata, we} = st;
        @(posedge clk); #1;
        we = 4'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (with_store) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(st);
            else exp_ovf = 1'b1;
        end
        n_checks++;
        if (count !== 5'(exp_q.size())) begin
            n_fail++;
            $display("FAIL pop_latency: count %0d expected %0d", count, exp_q.size());
        end
        repeat (hold - 3) begin @(posedge clk); #1; end
        pop_req = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (count !== 5'(exp_q.size()) || overflow !== exp_ovf) begin
            n_fail++;
            $display("FAIL pop_single: count %0d ovf %b expected %0d %b", count, overflow,
                     exp_q.size(), exp_ovf);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({count, empty, full, overflow} !== {5'd0, 3'b100} ||
            {head_pc, head_addr, head_data, head_we} !== 100'b0) begin
            n_fail++;
            $display("FAIL reset_init: count %0d empty %b full %b ovf %b", count, empty, full,
                     overflow);
        end
        for (int i = 0; i < 5; i++) do_store(mk(i + 100));
        n_checks++;
        if (count !== 5'd5) begin
            n_fail++;
            $display("FAIL reset_fill5: count %0d expected 5", count);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({count, empty, full, overflow} !== {5'd0, 3'b100} ||
            {head_pc, head_addr, head_data, head_we} !== 100'b0) begin
            n_fail++;
            $display("FAIL reset_async: count %0d empty %b ovf %b head_data %h expected 0 1 0 0",
                     count, empty, overflow, head_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
    endtask

    task automatic test_single();
        do_store({32'h10, 32'h40, 32'hDEADBEEF, 4'b1111});
        n_checks++;
        if ({head_pc, head_addr, head_data, head_we, count} !==
            {32'h10, 32'h40, 32'hDEADBEEF, 4'b1111, 5'd1}) begin
            n_fail++;
            $display("FAIL single_store: head %h %h %h %b count %0d", head_pc, head_addr,
                     head_data, head_we, count);
        end
        do_pop(3, 1'b0, 100'b0);
        n_checks++;
        if (empty !== 1'b1 || {head_pc, head_addr, head_data, head_we} !== 100'b0) begin
            n_fail++;
            $display("FAIL single_pop: empty %b head_data %h expected 1 0", empty, head_data);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 17; i++) do_store(mk(i));
        n_checks++;
        if ({full, overflow, count, head_data} !== {2'b11, 5'd16, 32'd1}) begin
            n_fail++;
            $display("FAIL fill_overflow: full %b ovf %b count %0d head_data %0d", full,
                     overflow, count, head_data);
        end
        for (int i = 0; i < 16; i++) do_pop(3, 1'b0, 100'b0);
        n_checks++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_overflow: empty %b ovf %b expected 1 1", empty, overflow);
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_ovf = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL clear_ovf: ovf %b count %0d expected 0 0", overflow, count);
        end
    endtask

    task automatic test_wrap_full();
        for (int i = 0; i < 3; i++) do_store(mk(200 + i));
        for (int i = 0; i < 3; i++) do_pop(3, 1'b0, 100'b0);
        for (int i = 0; i < 16; i++) do_store(mk(300 + i));
        do_pop(3, 1'b1, mk(400));
        n_checks++;
        if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_push_pop: count %0d ovf %b expected 16 0", count, overflow);
        end
        for (int i = 0; i < 16; i++) do_pop(3, 1'b0, 100'b0);
    endtask

    task automatic test_empty_edge();
        do_pop(3, 1'b0, 100'b0);
        do_pop(3, 1'b1, mk(50));
        n_checks++;
        if (count !== 5'd1 || {head_pc, head_addr, head_data, head_we} !== mk(50)) begin
            n_fail++;
            $display("FAIL empty_push_pop: count %0d head_data %h expected 1 %h", count,
                     head_data, mk(50));
        end
        do_store(mk(51));
        do_store(mk(52));
        do_pop(20, 1'b0, 100'b0);
        while (exp_q.size() > 0) do_pop(3, 1'b0, 100'b0);
    endtask

    task automatic test_clear_priority();
        for (int i = 0; i < 16; i++) do_store(mk(500 + i));
        clear = 1'b1;
        {pc, daddr, dwdata, we} = mk(600);
        @(posedge clk); #1;
        clear = 1'b0;
        we = 4'b0;
        exp_q.delete();
        n_checks++;
        if ({count, empty, full, overflow} !== {5'd0, 3'b100}) begin
            n_fail++;
            $display("FAIL clear_priority: count %0d empty %b ovf %b expected 0 1 0", count,
                     empty, overflow);
        end
    endtask

`ifdef STORE_TRACE_TIMESTAMP_EN
    task automatic test_timestamp();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        do_store(mk(700));
        n_checks++;
        if (head_ts !== 16'd3) begin
            n_fail++;
            $display("FAIL ts_first: head_ts %0d expected 3", head_ts);
        end
        repeat (95) begin @(posedge clk); #1; end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_q.delete();
        repeat (65439) begin @(posedge clk); #1; end
        do_store(mk(701));
        n_checks++;
        if (head_ts !== 16'd3) begin
            n_fail++;
            $display("FAIL ts_wrap: head_ts %0d expected 3", head_ts);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        we = 4'b0; pc = '0; daddr = '0; dwdata = '0;
        pop_req = 1'b0; clear = 1'b0; exp_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_wrap_full();
        test_empty_edge();
        test_clear_priority();
`ifdef STORE_TRACE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_trace_fifo.md
# store_trace_fifo

- Captures every data-memory store the pipelined CPU commits into a circular FIFO: PC, address, write data and byte-enable mask.
- Sits downstream of the CPU/dmem pair and feeds the VIO debug core.
- The VIO walks the stored history one entry at a time through a pop request.
- This provides a store history instead of only the live bus snapshot.

## Interface

Parameters:

- DEPTH, 16: number of entries. Must be a power of two, minimum 2.
- ADDR_W, 4: pointer width. Must equal log2(DEPTH).

Ports:

- clk  in  1  same clock that drives the CPU and dmem; all state on rising edge
- reset  in  1  asynchronous, active-high; clears pointers, count and flags
- we  in  4  CPU byte-enable for the store; any nonzero value marks a store
- PC  in  32  PC of the instruction issuing the store
- daddr  in  32  store address
- dwdata  in  32  store data
- pop_req  in  1  level from VIO, asynchronous to clk; each rising edge requests one pop
- clear  in  1  synchronous; empties the FIFO and clears overflow
- head_pc  out  32  PC of the oldest entry; 0 when empty
- head_addr  out  32  address of the oldest entry; 0 when empty
- head_data  out  32  data of the oldest entry; 0 when empty
- head_we  out  4  byte mask of the oldest entry; 0 when empty
- count  out  ADDR_W+1  number of valid entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky: set when a store was dropped because the FIFO was full

## Operation

Storage and pointers:

- Entry storage: DEPTH x 100 bits (PC, daddr, dwdata, we).
- Write pointer wr_ptr and read pointer rd_ptr, each ADDR_W bits, wrap DEPTH-1 -> 0.
- count is a separate ADDR_W+1-bit register, not derived from the pointers.

Push (on each edge where we != 0):

- If not full, or a pop occurs on the same edge: write the entry at wr_ptr, wr_ptr+1.
- Otherwise drop the store and set overflow.

Pop:

- pop_req passes through a 2-FF synchronizer (s1, s2) plus a delay FF s3.
- pop_pulse = s2 & ~s3.
- On pop_pulse, if count != 0: rd_ptr+1.
- A pop while empty is ignored, with no error flag.

Simultaneous events:

- Push and pop with 0 < count < DEPTH: both happen, count unchanged.
- Push and pop when full: both happen, count stays DEPTH, no overflow.
- Push and pop when empty: the push is accepted, the pop is ignored, count becomes 1.
- clear has priority over push and pop. On that edge: pointers 0, count 0, overflow 0, and any concurrent store is discarded without setting overflow.

Outputs:

- Head outputs are combinational reads at rd_ptr, forced to 0 when empty.

Reset:

- Values after reset: pointers 0, count 0, empty 1, full 0, overflow 0, all head outputs 0, s1/s2/s3 0.
- Entry storage is not reset.
- Asserting reset mid-operation discards all contents immediately, without waiting for a clock edge.

## Timing

- Push latency: a store sampled at edge N updates count, empty and full after edge N. If the FIFO was empty, the head outputs show the entry after edge N.
- Pop latency:
  - pop_req rises before edge N (setup met): s1 = 1 at N, s2 = 1 at N+1, pop_pulse is high for the cycle after N+1, rd_ptr advances at N+2.
  - When pop_req is asynchronous, allow one extra edge of uncertainty.
- Exactly one pop per pop_req rising edge, regardless of how long pop_req stays high.
- Minimum pop_req high and low time: 2 clk cycles.
- overflow sets at the edge that drops the store and holds until reset or clear.
- No throughput limit on pushes: one store per cycle is sustained until full.

## Configuration

- Macro `STORE_TRACE_TIMESTAMP_EN`.
- Defined:
  - A free-running 16-bit cycle counter ts_cnt is added: reset to 0, +1 every clk, wraps 0xFFFF -> 0x0000.
  - Each entry also stores ts_cnt as sampled at the capture edge.
  - Extra output port head_ts (out, 16 bits) carries the timestamp; 0 when empty.
  - clear does not reset ts_cnt.
- Undefined: no counter, no head_ts port, entry width 100 bits.

## Test plan

- **Reset defaults:** assert reset mid-run with count = 5 -> immediately count = 0, empty = 1, overflow = 0, all head outputs 0.
- **Single store, single pop:** store we = 4'b1111, PC = 0x10, daddr = 0x40, dwdata = 0xDEADBEEF, then pulse pop_req.
  - After the store: head shows those values, count = 1.
  - After the pop: count = 0, empty = 1, head outputs 0.
  - rd_ptr advances 2 edges after the pop_req rise is first sampled.
- **Fill and overflow:** 17 consecutive stores with dwdata = 1..17 and DEPTH = 16.
  - full = 1, count = 16, overflow = 1, head_data = 1.
  - 16 pops return dwdata 1..16 in order; 17 is never seen.
- **Wrap and full push+pop:** fill to 16, then a store on the same edge as pop_pulse.
  - count stays 16, overflow stays 0.
  - The new entry is read last after wr_ptr wraps to 0.
- **Empty edge cases:** pop on empty -> no change. Store on the same edge as pop_pulse while empty -> count = 1, entry preserved. Hold pop_req high for 20 cycles -> exactly one pop.
- **Timestamp (`STORE_TRACE_TIMESTAMP_EN` defined):** stores at cycles 3 and 65539 after reset -> head_ts = 3, then 3 after the pop (counter wrapped). clear at cycle 100 does not reset ts_cnt.
